// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer (req/ack imem port, redirect flush, stall hold).
// Optional build macro PC_ALIGN_CHECK_EN: misaligned jump/branch targets trap to EXC_VECTOR.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exception,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] epc,
  output logic        misalign
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0]  state;
  logic [31:0] pending;
  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] target;
`ifdef PC_ALIGN_CHECK_EN
  logic        target_bad;
`endif

  // Redirect priority: exception, then jump, then branch; exception vectors are never checked.
  always_comb begin
    redirect   = exception | jump | branch_taken;
    raw_target = jump ? jump_target : branch_target;
`ifdef PC_ALIGN_CHECK_EN
    target_bad = 1'b0;
    if (exception) begin
      target = EXC_VECTOR;
    end else if (raw_target[1:0] != 2'b00) begin
      target     = EXC_VECTOR;
      target_bad = redirect;
    end else begin
      target = raw_target;
    end
`else
    if (exception) begin
      target = EXC_VECTOR;
    end else begin
      target = raw_target & 32'hFFFF_FFFC;
    end
`endif
  end

  assign imem_req  = (state == FETCH) || (state == FLUSH);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      pending     <= 32'h0;
      fetch_valid <= 1'b0;
      fetch_pc    <= 32'h0;
      epc         <= 32'h0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (redirect && imem_ack) begin
            fetch_valid <= 1'b0;
            pc          <= target;
          end else if (redirect) begin
            fetch_valid <= 1'b0;
            pending     <= target;
            state       <= FLUSH;
          end else if (imem_ack) begin
            fetch_valid <= 1'b1;
            fetch_pc    <= pc;
            pc          <= pc + 32'd4;
            if (stall) state <= HOLD;
          end else begin
            fetch_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            fetch_valid <= 1'b0;
            pc          <= target;
            state       <= FETCH;
          end else if (!stall) begin
            fetch_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        FLUSH: begin
          // The in-flight fetch must complete before the address may change; its data is dropped.
          fetch_valid <= 1'b0;
          if (imem_ack) begin
            pc    <= redirect ? target : pending;
            state <= FETCH;
          end else if (redirect) begin
            pending <= target;
          end
        end
        default: state <= IDLE;
      endcase
      if ((state != IDLE) && exception) epc <= pc;
`ifdef PC_ALIGN_CHECK_EN
      if ((state != IDLE) && target_bad) epc <= raw_target;
`endif
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misalign <= 1'b0;
    else          misalign <= (state != IDLE) && target_bad;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule
